// File: rtl/io_port.sv
// io_port: register-mapped switch/LED peripheral.
// Switch inputs are synchronised and debounced per bit. Every accepted edge,
// rising or falling, latches into a per-bit event register that can raise irq.
// Ports:
//   clk, clr       clock, asynchronous active-low reset
//   swiches        raw asynchronous switch levels
//   leds           LED drive (LED register)
//   addr/wr_en/wdata/rd_en   register bus: 0 SW, 1 LED, 2 IEN, 3 EVT (W1C)
//   rdata/rvalid   read response, one cycle after rd_en
//   irq            |(EVT & IEN)
module io_port #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] swiches,
    output logic [WIDTH-1:0] leds,
    input  logic [1:0]       addr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             irq
);

    localparam int unsigned CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [1:0]  A_SW   = 2'd0;
    localparam logic [1:0]  A_LED  = 2'd1;
    localparam logic [1:0]  A_IEN  = 2'd2;
    localparam logic [1:0]  A_EVT  = 2'd3;

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [CW-1:0]    r_cnt  [WIDTH];
    logic [WIDTH-1:0] r_db;
    logic [WIDTH-1:0] r_led;
    logic [WIDTH-1:0] r_ien;
    logic [WIDTH-1:0] r_evt;
    logic [WIDTH-1:0] r_rdata;
    logic             r_rvalid;
    logic             r_irq;

    logic [WIDTH-1:0] w_s;
    logic [CW-1:0]    w_cnt_nxt [WIDTH];
    logic [WIDTH-1:0] w_db_nxt;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_led_nxt;
    logic [WIDTH-1:0] w_ien_nxt;
    logic [WIDTH-1:0] w_evt_nxt;
    logic [WIDTH-1:0] w_rd_mux;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign leds   = r_led;
    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign irq    = r_irq;

    // Input synchroniser chain, one per bit (all bits share the vector stages).
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= swiches;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    // Debounce: count consecutive cycles the synchronised level differs from db;
    // the count that would reach DEBOUNCE_CYCLES accepts the level and flags an edge.
    always_comb begin
        w_db_nxt = r_db;
        w_edge   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = '0;
            if (w_s[i] != r_db[i]) begin
                if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    w_db_nxt[i] = w_s[i];
                    w_edge[i]   = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Register writes; a new edge overrides a same-cycle W1C on its EVT bit.
    always_comb begin
        w_led_nxt = r_led;
        w_ien_nxt = r_ien;
        w_evt_nxt = r_evt;
        if (wr_en) begin
            case (addr)
                A_LED:   w_led_nxt = wdata;
                A_IEN:   w_ien_nxt = wdata;
                A_EVT:   w_evt_nxt = r_evt & ~wdata;
                default: ;
            endcase
        end
        w_evt_nxt = w_evt_nxt | w_edge;
    end

    // Read mux sees pre-write, pre-event register values.
    always_comb begin
        w_rd_mux = '0;
        case (addr)
            A_SW:    w_rd_mux = r_db;
            A_LED:   w_rd_mux = r_led;
            A_IEN:   w_rd_mux = r_ien;
            A_EVT:   w_rd_mux = r_evt;
            default: w_rd_mux = '0;
        endcase
    end

    // State registers; irq is built from next-state values so it tracks EVT/IEN on the same edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
            r_db     <= '0;
            r_led    <= '0;
            r_ien    <= '0;
            r_evt    <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= w_cnt_nxt[i];
            r_db     <= w_db_nxt;
            r_led    <= w_led_nxt;
            r_ien    <= w_ien_nxt;
            r_evt    <= w_evt_nxt;
            r_rvalid <= rd_en;
            if (rd_en) r_rdata <= w_rd_mux;
            r_irq    <= |(w_evt_nxt & w_ien_nxt);
        end
    end

endmodule

// File: tb/tb_io_port.sv
// tb_io_port: randomized + directed bench for io_port with a history-based
// reference model and a read-response scoreboard.
module tb_io_port;

    localparam int unsigned W    = 8;
    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 4;

    logic         clk;
    logic         clr;
    logic [W-1:0] swiches;
    logic [W-1:0] leds;
    logic [1:0]   addr;
    logic         wr_en;
    logic [W-1:0] wdata;
    logic         rd_en;
    logic [W-1:0] rdata;
    logic         rvalid;
    logic         irq;

    io_port #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .clr(clr), .swiches(swiches), .leds(leds),
        .addr(addr), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(rdata), .rvalid(rvalid), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a switch level is accepted once the last DEB samples seen
    // by the debouncer (raw samples delayed SYNC edges) all differ from db.
    logic [W-1:0] raw_hist [$];
    logic [W-1:0] m_db, m_led, m_ien, m_evt, m_ev, m_rd;
    logic         m_irq, m_rvalid;
    logic [W-1:0] exp_q [$];

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            raw_hist.delete();
            exp_q.delete();
            m_db = '0; m_led = '0; m_ien = '0; m_evt = '0;
            m_irq = 1'b0; m_rvalid = 1'b0;
        end else begin
            raw_hist.push_back(swiches);
            m_ev = '0;
            for (int b = 0; b < int'(W); b++) begin
                bit stable;
                stable = 1'b1;
                for (int j = 0; j < int'(DEB); j++) begin
                    int idx;
                    logic [W-1:0] smp;
                    idx = raw_hist.size() - 1 - int'(SYNC) - j;
                    smp = (idx >= 0) ? raw_hist[idx] : '0;
                    if (smp[b] == m_db[b]) stable = 1'b0;
                end
                m_ev[b] = stable;
            end
            m_rvalid = rd_en;
            if (rd_en) begin
                case (addr)
                    2'd0: m_rd = m_db;
                    2'd1: m_rd = m_led;
                    2'd2: m_rd = m_ien;
                    default: m_rd = m_evt;
                endcase
                exp_q.push_back(m_rd);
            end
            if (wr_en) begin
                case (addr)
                    2'd1: m_led = wdata;
                    2'd2: m_ien = wdata;
                    2'd3: m_evt = m_evt & ~wdata;
                    default: ;
                endcase
            end
            m_evt = m_evt | m_ev;
            m_db  = m_db ^ m_ev;
            m_irq = |(m_evt & m_ien);
        end
    end

    // Monitor: pops an expected read whenever the DUT presents rvalid.
    always @(negedge clk) begin
        if (clr) begin
            check("rvalid", 8'(rvalid), 8'(m_rvalid));
            if (rvalid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rdata: unexpected response %h at %0t", rdata, $time);
                end else begin
                    check("rdata", rdata, exp_q.pop_front());
                end
            end
            check("leds", leds, m_led);
            check("irq", 8'(irq), 8'(m_irq));
        end
    end

    task automatic cyc(input logic wr, input logic rd, input logic [1:0] a, input logic [W-1:0] d);
        wr_en = wr; rd_en = rd; addr = a; wdata = d;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 2'd0, '0);
    endtask

    initial begin
        clr = 1'b0; swiches = 8'h48; addr = '0; wr_en = 1'b0; wdata = '0; rd_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_leds", leds, 8'h00);
        check("rst_rvalid", 8'(rvalid), 8'h00);
        check("rst_irq", 8'(irq), 8'h00);
        clr = 1'b1;

        // Held inputs through reset debounce in after release
        idle(7);
        cyc(1'b0, 1'b1, 2'd0, '0);   check("sw_after_rst", rdata, 8'h48);
        cyc(1'b0, 1'b1, 2'd3, '0);   check("evt_after_rst", rdata, 8'h48);
        check("irq_ien0", 8'(irq), 8'h00);

        // Enable + W1C
        cyc(1'b1, 1'b0, 2'd2, 8'h08); check("irq_on", 8'(irq), 8'h01);
        cyc(1'b1, 1'b0, 2'd3, 8'h08); check("irq_off", 8'(irq), 8'h00);
        cyc(1'b0, 1'b1, 2'd3, '0);   check("evt_w1c", rdata, 8'h40);

        // Short bounce rejected
        swiches = 8'h49; idle(3);
        swiches = 8'h48; idle(8);
        cyc(1'b0, 1'b1, 2'd0, '0);   check("sw_bounce", rdata, 8'h48);
        cyc(1'b0, 1'b1, 2'd3, '0);   check("evt_bounce", rdata, 8'h40);

        // Long pulse accepted exactly on the 6th edge
        swiches = 8'h49; idle(5);
        cyc(1'b0, 1'b1, 2'd0, '0);   check("sw_edge5", rdata, 8'h48);
        cyc(1'b0, 1'b1, 2'd0, '0);   check("sw_edge6", rdata, 8'h49);
        cyc(1'b0, 1'b1, 2'd3, '0);   check("evt_pulse", rdata, 8'h41);

        // LED write, then read-with-write returns old value
        cyc(1'b1, 1'b0, 2'd1, 8'hA5); check("leds_a5", leds, 8'hA5);
        cyc(1'b1, 1'b1, 2'd1, 8'h5A); check("rd_old_led", rdata, 8'hA5);
        check("leds_5a", leds, 8'h5A);

        // W1C collides with new event on bit 1
        cyc(1'b1, 1'b0, 2'd2, 8'h02);
        swiches = 8'h4B; idle(8);
        check("irq_bit1", 8'(irq), 8'h01);
        swiches = 8'h49; idle(5);
        cyc(1'b1, 1'b0, 2'd3, 8'h02); check("irq_collide", 8'(irq), 8'h01);
        cyc(1'b0, 1'b1, 2'd3, '0);   check("evt_collide", rdata, 8'h43);
        cyc(1'b1, 1'b0, 2'd3, 8'h02); check("irq_clear", 8'(irq), 8'h00);

        // Async reset mid-debounce
        cyc(1'b1, 1'b0, 2'd1, 8'hFF);
        swiches = 8'hC9; idle(2);
        @(posedge clk); #3;
        clr = 1'b0; #1;
        check("async_leds", leds, 8'h00);
        check("async_rdata", rdata, 8'h00);
        check("async_rvalid", 8'(rvalid), 8'h00);
        check("async_irq", 8'(irq), 8'h00);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        idle(8);
        cyc(1'b0, 1'b1, 2'd3, '0);   check("evt_rearm", rdata, 8'hC9);
        cyc(1'b0, 1'b1, 2'd0, '0);   check("sw_rearm", rdata, 8'hC9);

        // Random traffic with bouncy switches
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 5) == 0) swiches = swiches ^ W'(1 << $urandom_range(0, W - 1));
            cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), W'($urandom));
        end
        idle(3);
        check("drain", 8'(exp_q.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
